// File: rtl/uart_bus_scheduler.sv
// Arbitrates a shared 8-bit bus between reads and writes to a parallel-bus UART chip,
// generating wrn/rdn strobes and keeping the external RAM deselected while the UART owns the bus.

module uart_bus_scheduler_checker (
    input logic clk,
    input logic rst,
    input logic wrn,
    input logic rdn,
    input logic bus_oe,
    input logic busy,
    input logic tx_ack,
    input logic rx_valid
);

    strobe_exclusive_a: assert property (@(posedge clk) disable iff (rst) (wrn || rdn))
        else $error("wrn and rdn low together");

    oe_needs_busy_a: assert property (@(posedge clk) disable iff (rst) (!bus_oe || busy))
        else $error("bus_oe while scheduler idle");

    ack_in_write_a: assert property (@(posedge clk) disable iff (rst) (!tx_ack || bus_oe))
        else $error("tx_ack outside write setup");

    rx_valid_after_strobe_a: assert property (@(posedge clk) disable iff (rst) (!rx_valid || (rdn && busy)))
        else $error("rx_valid outside read end");

endmodule

module uart_bus_scheduler #(
    parameter int unsigned STROBE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_req,
    input  logic [7:0] tx_data,
    output logic       tx_ack,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    input  logic       data_ready,
    input  logic       tbre,
    input  logic       tsre,
    output logic       wrn,
    output logic       rdn,
    output logic [7:0] bus_dout,
    output logic       bus_oe,
    input  logic [7:0] bus_din,
    output logic       ram_ce_n
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RD_LOW    = 3'd1,
        RD_END    = 3'd2,
        WR_SETUP  = 3'd3,
        WR_LOW    = 3'd4,
        WR_END    = 3'd5,
        WAIT_TBRE = 3'd6,
        WAIT_TSRE = 3'd7
    } state_t;

    localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYCLES - 1);
    localparam logic       SERVED_RX   = 1'b0;
    localparam logic       SERVED_TX   = 1'b1;

    state_t     state_r;
    logic [3:0] strobe_cnt_r;
    logic       last_served_r;
    logic       wrn_r;
    logic       rdn_r;
    logic       bus_oe_r;
    logic [7:0] bus_dout_r;
    logic [7:0] rx_data_r;
    logic       rx_valid_r;
    logic       tx_ack_r;
    logic       busy_r;

    // Scheduler FSM: every output is a register set on the edge that enters its state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            strobe_cnt_r  <= 4'd0;
            last_served_r <= SERVED_RX;
            wrn_r         <= 1'b1;
            rdn_r         <= 1'b1;
            bus_oe_r      <= 1'b0;
            bus_dout_r    <= 8'h00;
            rx_data_r     <= 8'h00;
            rx_valid_r    <= 1'b0;
            tx_ack_r      <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            tx_ack_r   <= 1'b0;
            rx_valid_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    // On a tie the side not served last wins.
                    if (tx_req && (!data_ready || (last_served_r == SERVED_RX))) begin
                        state_r       <= WR_SETUP;
                        bus_dout_r    <= tx_data;
                        tx_ack_r      <= 1'b1;
                        bus_oe_r      <= 1'b1;
                        busy_r        <= 1'b1;
                        last_served_r <= SERVED_TX;
                    end else if (data_ready) begin
                        state_r       <= RD_LOW;
                        rdn_r         <= 1'b0;
                        strobe_cnt_r  <= STROBE_LOAD;
                        busy_r        <= 1'b1;
                        last_served_r <= SERVED_RX;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RD_LOW: begin
                    if (strobe_cnt_r == 4'd0) begin
                        state_r    <= RD_END;
                        rx_data_r  <= bus_din;
                        rx_valid_r <= 1'b1;
                        rdn_r      <= 1'b1;
                    end else begin
                        strobe_cnt_r <= strobe_cnt_r - 4'd1;
                    end
                end
                RD_END: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
                WR_SETUP: begin
                    state_r      <= WR_LOW;
                    wrn_r        <= 1'b0;
                    strobe_cnt_r <= STROBE_LOAD;
                end
                WR_LOW: begin
                    if (strobe_cnt_r == 4'd0) begin
                        state_r <= WR_END;
                        wrn_r   <= 1'b1;
                    end else begin
                        strobe_cnt_r <= strobe_cnt_r - 4'd1;
                    end
                end
                WR_END: begin
                    state_r  <= WAIT_TBRE;
                    bus_oe_r <= 1'b0;
                end
                WAIT_TBRE: begin
                    if (tbre) begin
                        state_r <= WAIT_TSRE;
                    end else begin
                        state_r <= WAIT_TBRE;
                    end
                end
                WAIT_TSRE: begin
                    if (tsre) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        state_r <= WAIT_TSRE;
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    wrn_r    <= 1'b1;
                    rdn_r    <= 1'b1;
                    bus_oe_r <= 1'b0;
                    busy_r   <= 1'b0;
                end
            endcase
        end
    end

    assign wrn      = wrn_r;
    assign rdn      = rdn_r;
    assign bus_oe   = bus_oe_r;
    assign bus_dout = bus_dout_r;
    assign rx_data  = rx_data_r;
    assign rx_valid = rx_valid_r;
    assign tx_ack   = tx_ack_r;
    assign busy     = busy_r;
    assign ram_ce_n = busy_r;

    uart_bus_scheduler_checker u_checker (
        .clk      (clk),
        .rst      (rst),
        .wrn      (wrn_r),
        .rdn      (rdn_r),
        .bus_oe   (bus_oe_r),
        .busy     (busy_r),
        .tx_ack   (tx_ack_r),
        .rx_valid (rx_valid_r)
    );

endmodule

// File: doc/uart_bus_scheduler.md
UART_BUS_SCHEDULER -- requirements
Module: uart_bus_scheduler

Interface
REQ-001 The module SHALL have parameter STROBE_CYCLES, default 2, giving the width in clk cycles of each low pulse on wrn/rdn (legal range 1..15).
REQ-002 The module SHALL have port clk, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The module SHALL have port tx_req, input, 1 bit: requester has a byte to transmit.
REQ-005 The module SHALL have port tx_data, input, 8 bits: byte to transmit, valid while tx_req=1.
REQ-006 The module SHALL have port tx_ack, output, 1 bit: one-cycle pulse when tx_data is accepted.
REQ-007 The module SHALL have port rx_data, output, 8 bits: last byte read from the UART chip.
REQ-008 The module SHALL have port rx_valid, output, 1 bit: one-cycle pulse when rx_data is updated.
REQ-009 The module SHALL have port busy, output, 1 bit: 1 whenever state is not IDLE.
REQ-010 The module SHALL have port data_ready, input, 1 bit: UART chip holds a received byte.
REQ-011 The module SHALL have ports tbre and tsre, input, 1 bit each: UART transmit buffer empty and transmit shift register empty.
REQ-012 The module SHALL have ports wrn and rdn, output, 1 bit each: active-low UART write and read strobes.
REQ-013 The module SHALL have port bus_dout, output, 8 bits: value for the shared data bus.
REQ-014 The module SHALL have port bus_oe, output, 1 bit: 1 = drive bus_dout onto the shared bus; the top level does the tristate.
REQ-015 The module SHALL have port bus_din, input, 8 bits: shared data bus as sampled.
REQ-016 The module SHALL have port ram_ce_n, output, 1 bit: 1 = external RAM disabled; the RAM is off the bus whenever the UART owns it.

Function
REQ-017 The module SHALL implement states IDLE, RD_LOW, RD_END, WR_SETUP, WR_LOW, WR_END, WAIT_TBRE, WAIT_TSRE.
REQ-018 In IDLE with only data_ready=1, the module SHALL go to RD_LOW; with only tx_req=1, it SHALL go to WR_SETUP.
REQ-019 In IDLE with both data_ready=1 and tx_req=1, the module SHALL serve the side not served last, tracked by a last_served flag that is updated on every accept.
REQ-020 On the IDLE->WR_SETUP edge the module SHALL latch tx_data into bus_dout and pulse tx_ack for exactly that following cycle; tx_req may fall afterwards.
REQ-021 RD_LOW SHALL hold rdn=0 for STROBE_CYCLES cycles; on the last of these cycles it SHALL capture bus_din into rx_data, pulse rx_valid for one cycle, and then go to RD_END.
REQ-022 RD_END SHALL hold rdn=1 for one cycle and then return to IDLE.
REQ-023 WR_SETUP SHALL hold bus_oe=1 and wrn=1 for one cycle; WR_LOW SHALL hold bus_oe=1 and wrn=0 for STROBE_CYCLES cycles; WR_END SHALL hold bus_oe=1 and wrn=1 for one cycle.
REQ-024 WAIT_TBRE SHALL hold bus_oe=0 and wait for tbre=1; WAIT_TSRE SHALL then wait for tsre=1 and return to IDLE.
REQ-025 Neither wait state SHALL have a timeout.
REQ-026 ram_ce_n SHALL equal busy.
REQ-027 bus_oe SHALL be 1 only in WR_SETUP, WR_LOW and WR_END.
REQ-028 wrn and rdn SHALL never be 0 in the same cycle.
REQ-029 The strobe counter SHALL be 4 bits, load STROBE_CYCLES-1 on state entry, and exit at 0.
REQ-030 data_ready and tx_req SHALL be ignored outside IDLE; a request held through a transfer is arbitrated on return to IDLE.

Reset
REQ-031 With rst=1 at a clk edge, the module SHALL set state=IDLE, wrn=1, rdn=1, bus_oe=0, bus_dout=0, rx_data=0, rx_valid=0, tx_ack=0, busy=0, ram_ce_n=0 and last_served=RX, so TX wins the first tie.
REQ-032 Reset asserted mid-transfer SHALL abort the transfer, release the strobes and the bus on the same edge, and SHALL NOT produce any tx_ack or rx_valid pulse.

Verification
REQ-033 TX only: tx_req=1 with tx_data=0x5A at cycle 0, tbre and tsre held at 1 -> tx_ack at cycle 1; wrn=0 in cycles 2-3 with bus_dout=0x5A and bus_oe=1; IDLE by cycle 7.
REQ-034 RX only: data_ready=1 with bus_din=0xC3 -> rdn=0 for 2 cycles; rx_valid pulses once with rx_data=0xC3; rdn=1 for one cycle; then IDLE.
REQ-035 Tie after reset: data_ready=1 and tx_req=1 held together -> TX served first, then RX, then TX again (strict alternation); wrn and rdn never low together.
REQ-036 Reset during WR_LOW -> next cycle wrn=1, bus_oe=0, ram_ce_n=0, and no tx_ack pulse and no rx_valid pulse after reset.
REQ-037 tbre held at 0 for 20 cycles after WR_END -> busy=1 and ram_ce_n=1 throughout; IDLE two cycles after tbre and tsre rise.
REQ-038 STROBE_CYCLES=1 -> wrn and rdn low pulses are exactly 1 cycle wide.
